sensor_stream_sim: RTL
======================

SENSOR_STREAM_SIM -- requirements
Module: sensor_stream_sim

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  NUM_CH, 8, number of simulated sensor channels (1..16)
  DATA_W, 110, packet width in bits
  DEPTH, 64, packets per channel stream (power of 2)
  TIMER_W, 16, period timer width
  BASE_PERIOD, 30000, reset period of channel 0 in clocks
  PERIOD_STEP, 5000, reset period increment per channel index
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clock  in  1  single clock; all logic on its rising edge
  reset  in  1  synchronous, active-high reset
  ch_enable  in  NUM_CH  per-channel run enable
  wrap_mode  in  1  1 = stream index wraps to 0; 0 = channel stops after last packet
  period_load  in  1  one-cycle strobe that writes period_value to channel period_ch
  period_ch  in  $clog2(NUM_CH)  target channel for period_load
  period_value  in  TIMER_W  new period in clocks
  out_valid  out  1  out_data/out_channel hold a packet
  out_ready  in  1  consumer accepts the packet when out_valid=1
  out_channel  out  $clog2(NUM_CH)  source channel of the packet
  out_data  out  DATA_W  packet payload
  pending  out  NUM_CH  per-channel packet-due flags
  overrun  out  NUM_CH  sticky flag: timer expired while pending was already set
  exhausted  out  NUM_CH  channel finished its stream (wrap_mode=0)

Function
REQ-003 Each channel SHALL have a free-running timer that counts 0..period-1 while ch_enable[c]=1 and exhausted[c]=0, then returns to 0; the timer holds its value when disabled.
REQ-004 Timer expiry (count = period-1) SHALL set pending[c] on the next edge; if pending[c] is already 1 and not being cleared that cycle, overrun[c] SHALL be set and remain set until reset.
REQ-005 Expiry in the same cycle that pending[c] is cleared by a handshake SHALL leave pending[c]=1 and SHALL NOT set overrun[c].
REQ-006 period_load SHALL write period_value to channel period_ch and restart that timer at 0; period_value=0 SHALL be ignored, with the register left unchanged.
REQ-007 The FSM SHALL have states IDLE, SELECT, FETCH and SEND.
REQ-008 IDLE -> SELECT when any pending bit is 1; otherwise the FSM stays in IDLE.
REQ-009 In SELECT the FSM SHALL grant round-robin: the lowest-index pending channel strictly after the last granted channel, wrapping to channel 0; after reset the last granted channel is NUM_CH-1. SELECT -> FETCH always.
REQ-010 In FETCH the FSM SHALL register the ROM word for (granted channel, index[granted]) into out_data and set out_channel. FETCH -> SEND always.
REQ-011 In SEND out_valid SHALL be 1, and out_data and out_channel SHALL stay stable until out_ready=1. When out_valid and out_ready are both 1: clear pending[granted], advance index[granted], drop out_valid on the next edge, and return to IDLE.
REQ-012 Latency SHALL be 3 clocks from the pending flag set to out_valid when idle and uncontended.
REQ-013 Index advance SHALL work as follows: if index = DEPTH-1 and wrap_mode=1, index goes to 0; if wrap_mode=0, index holds and exhausted[c] is set, which also clears that channel's pending and stops its timer.
REQ-014 Deasserting ch_enable[c] SHALL NOT clear pending[c]; a packet already granted SHALL complete its handshake.

Reset
REQ-015 When reset=1, on the next edge all of the following SHALL apply: timers=0; indices=0; periods = BASE_PERIOD + c*PERIOD_STEP; pending, overrun and exhausted = 0; out_valid=0; out_data=0; out_channel=0; FSM in IDLE; last granted channel = NUM_CH-1.
REQ-016 A reset during SEND SHALL drop out_valid on the next edge and discard the packet.

Structure
REQ-017 The shared package SHALL hold the FSM state enum and the default period constants.
REQ-018 Packet storage SHALL be one sub-module, sensor_stream_rom: combinational (channel, index) -> DATA_W word.

Verification
REQ-019 The bench SHALL cover these scenarios, with NUM_CH=4, DEPTH=4 and periods 10, 12, 14, 16 loaded after reset:
  V1: out_ready=1, only channel 0 enabled -> out_valid pulses every 10 clocks, index 0,1,2,3,0 with wrap_mode=1, packet 3 clocks after pending.
  V2: all channels expire in the same cycle -> grants in order 0,1,2,3 with no overrun.
  V3: out_ready=0 for 25 clocks with channel 0 enabled -> overrun[0]=1; out_data stays stable through the stall.
  V4: wrap_mode=0 and channel 1 only -> 4 packets, then exhausted[1]=1 and no further pending[1].
  V5: reset asserted during SEND -> out_valid=0 next clock; all flags and indices at reset values.
  V6: period_load of 0 -> period unchanged; period_load of 5 -> next expiry 5 clocks later.

Source files
------------

// File: rtl/sensor_stream_sim_pkg.sv
// Shared definitions for the sensor stream simulator.
//   state_t          : packet FSM states
//   DEF_BASE_PERIOD  : default reset period of channel 0 (clocks)
//   DEF_PERIOD_STEP  : default per-channel period increment (clocks)
package sensor_stream_sim_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_FETCH,
    S_SEND
  } state_t;

  localparam int DEF_BASE_PERIOD = 30000;
  localparam int DEF_PERIOD_STEP = 5000;

endpackage

// File: rtl/sensor_stream_rom.sv
// Packet store: combinational (channel, index) -> DATA_W word.
// Each 32-bit slice k of the word is {8'h5A+k, channel, index[15:0]},
// truncated to DATA_W, so any packet identifies its source and position.
// Ports:
//   i_ch   : channel number
//   i_idx  : packet index within the channel stream
//   o_data : packet payload
module sensor_stream_rom
  import sensor_stream_sim_pkg::*;
#(
  parameter int DATA_W = 110,
  parameter int CH_W   = 3,
  parameter int IDX_W  = 6
) (
  input  logic [CH_W-1:0]   i_ch,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_data
);

  localparam int NCHK = (DATA_W + 31) / 32;

  logic [NCHK*32-1:0] w_full;

  for (genvar k = 0; k < NCHK; k++) begin : g_chk
    assign w_full[k*32 +: 32] = {8'(8'h5A + k), 8'(i_ch), 16'(i_idx)};
  end

  assign o_data = w_full[DATA_W-1:0];

endmodule

// File: rtl/sensor_stream_sim.sv
// Simulated multi-channel sensor: each channel has a period timer; on expiry
// the channel raises pending, a round-robin FSM picks a pending channel,
// fetches its next packet from the ROM and offers it on a valid/ready port.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   ch_enable           : per-channel run enable
//   wrap_mode           : 1 = stream wraps, 0 = channel stops after last packet
//   period_load/_ch/_value : one-cycle period write (value 0 ignored)
//   out_valid/out_ready : packet handshake
//   out_channel/out_data: packet source and payload
//   pending/overrun/exhausted : per-channel status
module sensor_stream_sim
  import sensor_stream_sim_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 110,
  parameter int DEPTH       = 64,
  parameter int TIMER_W     = 16,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int PERIOD_STEP = DEF_PERIOD_STEP,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  ch_enable,
  input  logic               wrap_mode,
  input  logic               period_load,
  input  logic [CH_W-1:0]    period_ch,
  input  logic [TIMER_W-1:0] period_value,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_channel,
  output logic [DATA_W-1:0]  out_data,
  output logic [NUM_CH-1:0]  pending,
  output logic [NUM_CH-1:0]  overrun,
  output logic [NUM_CH-1:0]  exhausted
);

  state_t                          r_state, w_state_nx;
  logic [NUM_CH-1:0][TIMER_W-1:0]  r_cnt, r_per;
  logic [NUM_CH-1:0][IDX_W-1:0]    r_idx;
  logic [NUM_CH-1:0]               r_pend, r_ovr, r_exh;
  // r_grant doubles as the round-robin "last granted" pointer.
  logic [CH_W-1:0]                 r_grant, r_chan;
  logic [DATA_W-1:0]               r_data;

  logic [NUM_CH-1:0] w_run, w_exp, w_load, w_clr, w_last, w_exh_set;
  logic              w_hs;
  logic [CH_W-1:0]   w_pick, w_cand;
  logic [DATA_W-1:0] w_rom;

  assign w_hs = (r_state == S_SEND) && out_ready;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_run[c]     = ch_enable[c] && !r_exh[c];
      w_exp[c]     = w_run[c] && (r_cnt[c] == r_per[c] - TIMER_W'(1));
      w_load[c]    = period_load && (period_ch == CH_W'(c)) && (period_value != '0);
      w_clr[c]     = w_hs && (r_grant == CH_W'(c));
      w_last[c]    = (r_idx[c] == IDX_W'(DEPTH - 1));
      w_exh_set[c] = w_clr[c] && w_last[c] && !wrap_mode;
    end
  end

  // Scan from farthest to nearest so the nearest pending channel after the
  // last grant is the final (winning) assignment.
  always_comb begin
    w_pick = r_grant;
    w_cand = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_cand = CH_W'((int'(r_grant) + k) % NUM_CH);
      if (r_pend[w_cand]) w_pick = w_cand;
    end
  end

  sensor_stream_rom #(
    .DATA_W (DATA_W),
    .CH_W   (CH_W),
    .IDX_W  (IDX_W)
  ) u_rom (
    .i_ch   (r_grant),
    .i_idx  (r_idx[r_grant]),
    .o_data (w_rom)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:   if (|r_pend) w_state_nx = S_SELECT;
      S_SELECT: w_state_nx = S_FETCH;
      S_FETCH:  w_state_nx = S_SEND;
      S_SEND:   if (out_ready) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= CH_W'(NUM_CH - 1);
      r_chan  <= '0;
      r_data  <= '0;
      r_pend  <= '0;
      r_ovr   <= '0;
      r_exh   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= '0;
        r_per[c] <= TIMER_W'(BASE_PERIOD + c * PERIOD_STEP);
        r_idx[c] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_SELECT) r_grant <= w_pick;
      if (r_state == S_FETCH) begin
        r_data <= w_rom;
        r_chan <= r_grant;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_load[c]) begin
          r_per[c] <= period_value;
          r_cnt[c] <= '0;
        end else if (w_run[c]) begin
          r_cnt[c] <= w_exp[c] ? '0 : r_cnt[c] + TIMER_W'(1);
        end
        // Expiry coinciding with the handshake re-arms pending without overrun.
        if (w_exp[c] && r_pend[c] && !w_clr[c]) r_ovr[c] <= 1'b1;
        if (w_exh_set[c]) begin
          r_exh[c]  <= 1'b1;
          r_pend[c] <= 1'b0;
        end else if (w_exp[c]) begin
          r_pend[c] <= 1'b1;
        end else if (w_clr[c]) begin
          r_pend[c] <= 1'b0;
        end
        if (w_clr[c] && !w_last[c]) r_idx[c] <= r_idx[c] + IDX_W'(1);
        else if (w_clr[c] && wrap_mode) r_idx[c] <= '0;
      end
    end
  end

  assign out_valid   = (r_state == S_SEND);
  assign out_channel = r_chan;
  assign out_data    = r_data;
  assign pending     = r_pend;
  assign overrun     = r_ovr;
  assign exhausted   = r_exh;

endmodule
